comparator_scan_ctrl: RTL and testbench

//   Sequences the comparator injector through a halfstrip scan. For each step it

---
 rtl/comparator_scan_ctrl_pkg.sv | 18 +
 rtl/comparator_scan_ctrl_if.sv | 30 +++
 rtl/comparator_scan_ctrl_timer.sv | 27 ++
 rtl/comparator_scan_ctrl.sv | 171 +++++++++++++++++
 tb/tb_comparator_scan_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/comparator_scan_ctrl_pkg.sv
// Shared types for the comparator halfstrip scan controller.
package comptest_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CONFIG,
        SETTLE,
        FIRE,
        WAIT_BUSY,
        WAIT_DONE,
        REPORT,
        DONE
    } scan_state_t;

    // {step padded to 8b, halfstrips_errcnt, compout_errcnt}
    localparam int RESULT_W = 72;

endpackage

// File: rtl/comparator_scan_ctrl_if.sv
// Injector handshake plus the result stream, bundled as one bus.
interface comparator_scan_ctrl_if;
    import comptest_pkg::*;

    logic                fire_pulse;
    logic                pulser_ready;
    logic [31:0]         halfstrips_expect;
    logic [31:0]         halfstrips_errcnt;
    logic [31:0]         compout_errcnt;
    logic                halfstrips_errcnt_rst;
    logic                compout_errcnt_rst;
    logic                result_valid;
    logic                result_ready;
    logic [RESULT_W-1:0] result_data;

    // Scan controller side
    modport master (
        output fire_pulse, halfstrips_expect, halfstrips_errcnt_rst, compout_errcnt_rst,
               result_valid, result_data,
        input  pulser_ready, halfstrips_errcnt, compout_errcnt, result_ready
    );

    // Injector / result consumer side
    modport slave (
        input  fire_pulse, halfstrips_expect, halfstrips_errcnt_rst, compout_errcnt_rst,
               result_valid, result_data,
        output pulser_ready, halfstrips_errcnt, compout_errcnt, result_ready
    );

endinterface

// File: rtl/comparator_scan_ctrl_timer.sv
// Cycle counter bounding each wait on a pulser_ready edge.
module scan_handshake_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [TW-1:0] tcnt;

    // Clear wins over count; holds at TIMEOUT until cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tcnt <= '0;
        else if (clr)
            tcnt <= '0;
        else if (en && !expired)
            tcnt <= tcnt + 1'b1;
    end

    assign expired = (tcnt == TW'(TIMEOUT));

endmodule

// File: rtl/comparator_scan_ctrl.sv
// Halfstrip scan sequencer: per step, configure the injector, fire N pulses
// through the ready/fire handshake and post one result word.
module comparator_scan_ctrl
    import comptest_pkg::*;
#(
    parameter int STEP_W   = 5,
    parameter int NPULSE_W = 16,
    parameter int SETTLE_W = 8,
    parameter int TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [STEP_W:0]     num_steps,
    input  logic [NPULSE_W-1:0] num_pulses,
    input  logic [SETTLE_W-1:0] settle_cycles,
    comparator_scan_ctrl_if.master bus,
    output logic [STEP_W-1:0]   step,
    output logic                busy,
    output logic                done,
    output logic                timeout_err
);
    localparam logic [STEP_W:0] MAX_STEPS = (STEP_W+1)'(2 ** STEP_W);

    scan_state_t state, next_state;

    logic [STEP_W:0]     nsteps_q;
    logic [NPULSE_W-1:0] npulse_q;
    logic [SETTLE_W-1:0] settle_q;
    logic [NPULSE_W-1:0] pcnt;
    logic [SETTLE_W-1:0] scnt;
    logic [STEP_W-1:0]   step_q;

    logic                fire_q, rst_q, valid_q, done_q, busy_q, tout_q;
    logic [31:0]         expect_q;
    logic [RESULT_W-1:0] data_q;

    logic tmr_clr, tmr_en, tmr_expired, timeout_hit;
    logic last_step, more_pulses;

    assign last_step   = ({1'b0, step_q} == (nsteps_q - 1'b1));
    assign more_pulses = (({1'b0, pcnt} + 1'b1) < {1'b0, npulse_q});

    scan_handshake_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next state and timer control; abort overrides everything.
    always_comb begin
        next_state  = state;
        tmr_clr     = 1'b0;
        tmr_en      = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE:      if (start) next_state = (num_steps == '0) ? DONE : CONFIG;
            CONFIG:    next_state = SETTLE;
            SETTLE:    if (scnt == settle_q) next_state = (npulse_q == '0) ? REPORT : FIRE;
            FIRE: begin
                if (bus.pulser_ready) begin
                    tmr_clr    = 1'b1;
                    next_state = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                tmr_en = 1'b1;
                if (!bus.pulser_ready) begin
                    tmr_clr    = 1'b1;
                    next_state = WAIT_DONE;
                end else if (tmr_expired) begin
                    timeout_hit = 1'b1;
                    next_state  = REPORT;
                end
            end
            WAIT_DONE: begin
                tmr_en = 1'b1;
                if (bus.pulser_ready) begin
                    next_state = more_pulses ? FIRE : REPORT;
                end else if (tmr_expired) begin
                    timeout_hit = 1'b1;
                    next_state  = REPORT;
                end
            end
            REPORT:    if (valid_q && bus.result_ready) next_state = last_step ? DONE : CONFIG;
            DONE:      next_state = IDLE;
            default:   next_state = IDLE;
        endcase
        if (abort) begin
            next_state  = IDLE;
            timeout_hit = 1'b0;
        end
    end

    // Datapath and registered outputs, all derived from the current transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nsteps_q <= '0;
            npulse_q <= '0;
            settle_q <= '0;
            pcnt     <= '0;
            scnt     <= '0;
            step_q   <= '0;
            fire_q   <= 1'b0;
            rst_q    <= 1'b0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            tout_q   <= 1'b0;
            expect_q <= '0;
            data_q   <= '0;
        end else begin
            fire_q <= (state == FIRE) && (next_state == WAIT_BUSY);
            rst_q  <= (state == CONFIG) && !abort;
            done_q <= (next_state == DONE) && (state != DONE);
            busy_q <= !((next_state == IDLE) || (next_state == DONE));
            if (timeout_hit) tout_q <= 1'b1;

            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        // Saturate so the step counter can never wrap.
                        nsteps_q <= (num_steps > MAX_STEPS) ? MAX_STEPS : num_steps;
                        npulse_q <= num_pulses;
                        settle_q <= settle_cycles;
                        step_q   <= '0;
                        tout_q   <= 1'b0;
                    end
                end
                CONFIG: begin
                    expect_q <= 32'h1 << step_q;
                    pcnt     <= '0;
                    scnt     <= '0;
                end
                SETTLE:    scnt <= scnt + 1'b1;
                WAIT_DONE: if (bus.pulser_ready) pcnt <= pcnt + 1'b1;
                REPORT:    if (next_state == CONFIG) step_q <= step_q + 1'b1;
                default: ;
            endcase

            // Counts are captured as REPORT is entered and held while valid.
            if ((next_state == REPORT) && (state != REPORT)) begin
                valid_q <= 1'b1;
                data_q  <= {8'(step_q), bus.halfstrips_errcnt, bus.compout_errcnt};
            end else if (abort || ((state == REPORT) && valid_q && bus.result_ready)) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.fire_pulse            = fire_q;
    assign bus.halfstrips_expect     = expect_q;
    assign bus.halfstrips_errcnt_rst = rst_q;
    assign bus.compout_errcnt_rst    = rst_q;
    assign bus.result_valid          = valid_q;
    assign bus.result_data           = data_q;
    assign step                      = step_q;
    assign busy                      = busy_q;
    assign done                      = done_q;
    assign timeout_err               = tout_q;

endmodule

// File: tb/tb_comparator_scan_ctrl.sv
// Directed bench for comparator_scan_ctrl with a small behavioural injector.
module tb_comparator_scan_ctrl;
    localparam int STEP_W   = 5;
    localparam int NPULSE_W = 16;
    localparam int SETTLE_W = 8;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic                abort = 1'b0;
    logic [STEP_W:0]     num_steps = '0;
    logic [NPULSE_W-1:0] num_pulses = '0;
    logic [SETTLE_W-1:0] settle_cycles = '0;
    logic [STEP_W-1:0]   step;
    logic                busy, done, timeout_err;

    int n_assert = 0;
    int n_fail   = 0;

    comparator_scan_ctrl_if bus ();

    comparator_scan_ctrl #(
        .STEP_W(STEP_W), .NPULSE_W(NPULSE_W), .SETTLE_W(SETTLE_W), .TIMEOUT(255)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .num_steps(num_steps), .num_pulses(num_pulses), .settle_cycles(settle_cycles),
        .bus(bus), .step(step), .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Injector model: busy for 7 cycles per fire (pulse width 2 + bx delay 5);
    // counters update one cycle before ready rises.
    logic        model_en  = 1'b1;
    logic        mis_mode  = 1'b0;
    logic        rdy_ready = 1'b1;
    logic        model_ready;
    logic [31:0] hs_cnt, co_cnt;
    int          busy_cnt, pulse_idx;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_ready <= 1'b1;
            hs_cnt      <= '0;
            co_cnt      <= '0;
            busy_cnt    <= 0;
            pulse_idx   <= 0;
        end else begin
            if (bus.halfstrips_errcnt_rst) begin
                hs_cnt    <= '0;
                pulse_idx <= 0;
            end
            if (bus.compout_errcnt_rst) co_cnt <= '0;
            if (busy_cnt > 0) begin
                busy_cnt <= busy_cnt - 1;
                if (busy_cnt == 2 && mis_mode && (pulse_idx % 2 == 0)) begin
                    hs_cnt <= hs_cnt + 1;
                    co_cnt <= co_cnt + 1;
                end
                if (busy_cnt == 1) model_ready <= 1'b1;
            end else if (bus.fire_pulse && model_en) begin
                model_ready <= 1'b0;
                busy_cnt    <= 7;
                pulse_idx   <= pulse_idx + 1;
            end
        end
    end

    assign bus.pulser_ready      = model_ready;
    assign bus.halfstrips_errcnt = hs_cnt;
    assign bus.compout_errcnt    = co_cnt;
    assign bus.result_ready      = rdy_ready;

    // Event monitor: counts strobes and records accepted results.
    int          n_fire = 0, n_done = 0, n_hrst = 0, n_crst = 0;
    logic [71:0] res_q[$];
    logic [31:0] exp_q[$];

    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.fire_pulse)            n_fire <= n_fire + 1;
            if (done)                      n_done <= n_done + 1;
            if (bus.halfstrips_errcnt_rst) n_hrst <= n_hrst + 1;
            if (bus.compout_errcnt_rst)    n_crst <= n_crst + 1;
            if (bus.result_valid && bus.result_ready) begin
                res_q.push_back(bus.result_data);
                exp_q.push_back(bus.halfstrips_expect);
            end
        end
    end

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic kick(input int ns, input int np, input int st);
        num_steps     = (STEP_W+1)'(ns);
        num_pulses    = NPULSE_W'(np);
        settle_cycles = SETTLE_W'(st);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max, input string tag);
        int i;
        for (i = 0; i < max; i++) begin
            if (done) break;
            @(negedge clk);
        end
        check(tag, 72'(i < max), 72'd1);
        @(negedge clk);
    endtask

    task automatic wait_cond_valid(input int max, input string tag);
        int i;
        for (i = 0; i < max; i++) begin
            if (bus.result_valid) break;
            @(negedge clk);
        end
        check(tag, 72'(i < max), 72'd1);
    endtask

    initial begin
        int bf, bd, br, bh, bc, bad, i;
        logic [71:0] d0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy",   72'(busy), 72'd0);
        check("rst_fire",   72'(bus.fire_pulse), 72'd0);
        check("rst_expect", 72'(bus.halfstrips_expect), 72'd0);
        check("rst_valid",  72'(bus.result_valid), 72'd0);
        check("rst_data",   bus.result_data, 72'd0);
        check("rst_step",   72'(step), 72'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: three steps, four pulses each, error-free
        bf = n_fire; bd = n_done; br = res_q.size();
        kick(3, 4, 2);
        check("s1_busy", 72'(busy), 72'd1);
        wait_done(2000, "s1_done_wait");
        check("s1_nres", 72'(res_q.size() - br), 72'd3);
        for (i = 0; i < 3; i++) begin
            check($sformatf("s1_data%0d", i), res_q[br+i], {8'(i), 32'd0, 32'd0});
            check($sformatf("s1_exp%0d", i), 72'(exp_q[br+i]), 72'(32'h1 << i));
        end
        check("s1_fires", 72'(n_fire - bf), 72'd12);
        check("s1_dones", 72'(n_done - bd), 72'd1);
        check("s1_tout",  72'(timeout_err), 72'd0);
        check("s1_idle",  72'(busy), 72'd0);

        // 2: ten pulses, every second one mismatching
        mis_mode = 1'b1;
        br = res_q.size(); bf = n_fire;
        kick(1, 10, 0);
        wait_done(2000, "s2_done_wait");
        check("s2_nres",  72'(res_q.size() - br), 72'd1);
        check("s2_data",  res_q[br], {8'd0, 32'd5, 32'd5});
        check("s2_fires", 72'(n_fire - bf), 72'd10);
        mis_mode = 1'b0;

        // 3: ready stuck high, injector detached -> timeouts, scan completes
        model_en = 1'b0;
        br = res_q.size(); bf = n_fire;
        kick(2, 3, 0);
        wait_done(2000, "s3_done_wait");
        check("s3_tout",  72'(timeout_err), 72'd1);
        check("s3_nres",  72'(res_q.size() - br), 72'd2);
        check("s3_data0", res_q[br],   {8'd0, 32'd0, 32'd0});
        check("s3_data1", res_q[br+1], {8'd1, 32'd0, 32'd0});
        check("s3_fires", 72'(n_fire - bf), 72'd2);
        model_en = 1'b1;

        // 4: consumer stalls for 50 cycles in REPORT
        rdy_ready = 1'b0;
        br = res_q.size();
        kick(2, 1, 0);
        check("s4_tout_clr", 72'(timeout_err), 72'd0);
        wait_cond_valid(500, "s4_valid_wait");
        d0 = bus.result_data;
        bf = n_fire;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (!bus.result_valid || bus.result_data !== d0 || step !== '0) bad++;
        end
        check("s4_stable", 72'(bad), 72'd0);
        check("s4_data",   d0, {8'd0, 32'd0, 32'd0});
        check("s4_nofire", 72'(n_fire - bf), 72'd0);
        check("s4_step0",  72'(step), 72'd0);
        rdy_ready = 1'b1;
        @(negedge clk);
        check("s4_step1",  72'(step), 72'd1);
        wait_done(500, "s4_done_wait");
        check("s4_nres",   72'(res_q.size() - br), 72'd2);
        check("s4_data1",  res_q[br+1], {8'd1, 32'd0, 32'd0});

        // 5: abort in WAIT_DONE on step 1, then a clean rerun
        br = res_q.size();
        kick(3, 3, 1);
        for (i = 0; i < 1000; i++) begin
            if (step == 5'd1 && !model_ready) break;
            @(negedge clk);
        end
        check("s5_reach", 72'(i < 1000), 72'd1);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("s5_busy",  72'(busy), 72'd0);
        check("s5_valid", 72'(bus.result_valid), 72'd0);
        bf = n_fire;
        repeat (100) @(negedge clk);
        check("s5_nres",   72'(res_q.size() - br), 72'd1);
        check("s5_nofire", 72'(n_fire - bf), 72'd0);
        br = res_q.size();
        kick(2, 2, 0);
        wait_done(1000, "s5_rerun_wait");
        check("s5_rerun_n",  72'(res_q.size() - br), 72'd2);
        check("s5_rerun_d0", res_q[br],   {8'd0, 32'd0, 32'd0});
        check("s5_rerun_d1", res_q[br+1], {8'd1, 32'd0, 32'd0});

        // start and abort together: abort wins
        abort = 1'b1;
        kick(2, 2, 0);
        abort = 1'b0;
        check("s6_startabort", 72'(busy), 72'd0);
        @(negedge clk);
        check("s6_startabort2", 72'(busy), 72'd0);

        // 6a: zero steps
        bf = n_fire; bh = n_hrst; br = res_q.size();
        kick(0, 4, 0);
        wait_done(2, "s6_zero_done");
        check("s6_zero_fire", 72'(n_fire - bf), 72'd0);
        check("s6_zero_rst",  72'(n_hrst - bh), 72'd0);
        check("s6_zero_res",  72'(res_q.size() - br), 72'd0);

        // 6b: zero pulses
        bf = n_fire; bh = n_hrst; bc = n_crst; br = res_q.size();
        kick(2, 0, 1);
        wait_done(200, "s6_np0_done");
        check("s6_np0_fire", 72'(n_fire - bf), 72'd0);
        check("s6_np0_hrst", 72'(n_hrst - bh), 72'd2);
        check("s6_np0_crst", 72'(n_crst - bc), 72'd2);
        check("s6_np0_nres", 72'(res_q.size() - br), 72'd2);

        // 6c: async reset mid-scan
        br = res_q.size();
        kick(3, 4, 2);
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("s6_rst_busy",   72'(busy), 72'd0);
        check("s6_rst_expect", 72'(bus.halfstrips_expect), 72'd0);
        check("s6_rst_fire",   72'(bus.fire_pulse), 72'd0);
        check("s6_rst_valid",  72'(bus.result_valid), 72'd0);
        check("s6_rst_step",   72'(step), 72'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check("s6_rst_nres",  72'(res_q.size() - br), 72'd0);
        check("s6_rst_idle",  72'(busy), 72'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
